arbiter_rr_hold: RTL
====================

Name: arbiter_rr_hold

Overview:
- N-way round-robin arbiter that shares one resource between requesters.
- Adds a bounded-tenure hold: the owner keeps the grant while its request stays high, but for at most HOLD_MAX cycles when others are waiting.
- Grants are registered one-hot; an encoded owner index is also provided.
- Sits between requester agents and a shared resource port, as the fairness-enforcing successor to the fixed 2-way arbiter.

Parameters:
- N, 4: number of requesters (2..16).
- HOLD_MAX, 8: maximum consecutive grant cycles while another requester waits (>=1).
- IDW, $clog2(N): width of the owner index.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- req  in  N  request vector; bit i is held high by requester i while it wants or uses the resource.
- gnt  out  N  registered one-hot grant; all-zero when idle.
- gnt_vld  out  1  high when gnt is non-zero.
- gnt_id  out  IDW  index of the current owner; valid only when gnt_vld is high.
- lock  in  1  present only with ARB_RR_LOCK_EN (see Optional Feature).

Behaviour:
- Reset (async, rst=1):
  - gnt=0, gnt_vld=0, gnt_id=0.
  - state=IDLE, ptr=0, hold_cnt=0.
  - Reset asserted mid-grant drops the grant immediately. After release, arbitration restarts from ptr=0.
- Pick function: lowest index j >= ptr with req[j]=1, wrapping modulo N. An exclude mask removes the current owner from the search.
- Priority update: on every new grant to requester k, ptr <= (k+1) mod N. Wraps from N-1 to 0.
- FSM states: IDLE, GRANT.
- IDLE:
  - req=0: stay in IDLE, outputs zero.
  - req!=0: next cycle gnt=onehot(pick), gnt_id=pick, gnt_vld=1, hold_cnt=0, go to GRANT.
  - Request-to-grant latency is 1 cycle.
- GRANT, owner o:
  - release (req[o]=0):
    - If any other requester is high, grant it next cycle (back-to-back, no bubble), hold_cnt=0.
    - Otherwise next cycle gnt=0 and state goes to IDLE.
  - expire (req[o]=1, hold_cnt==HOLD_MAX-1, some other req high): grant pick-excluding-o next cycle, hold_cnt=0.
  - continue (req[o]=1, not expire):
    - gnt unchanged.
    - hold_cnt increments only while another requester waits; it resets to 0 when no other request is present.
    - A lone owner therefore holds indefinitely.
- hold_cnt width is $clog2(HOLD_MAX)+1 and never exceeds HOLD_MAX-1.
- New requests arriving while a grant is held have no effect until release or expire.
- gnt is always one-hot or zero, and is never granted to a requester whose req is low at the decision edge.
- Starvation bound: any continuously asserted request is granted within (N-1)*HOLD_MAX+1 cycles.

Optional Feature:
- Macro: ARB_RR_LOCK_EN.
- Defined:
  - The lock input exists.
  - While lock=1 in GRANT, expire is suppressed and hold_cnt is frozen; release still ends the tenure.
  - lock is ignored in IDLE.
- Undefined: no lock port; behaviour is exactly as above.

Decomposition:
- Package arbiter_rr_pkg holds:
  - defaults N_REQ=4 and HOLD_MAX_DEF=8;
  - typedef enum logic {IDLE, GRANT} arb_state_e;
  - typedefs req_t, gnt_t (logic [N_REQ-1:0]) and id_t (logic [$clog2(N_REQ)-1:0]).
- One combinational sub-module, rr_pick:
  - inputs: req, ptr, excl_mask;
  - outputs: found and idx;
  - implementation: rotate, priority-encode, un-rotate.
- The top level holds the FSM, ptr, hold_cnt and output registers.

Test Plan (N=4, HOLD_MAX=8):
- Reset: assert rst mid-cycle while gnt=4'b0010 -> gnt=0 and gnt_vld=0 immediately. After deassert with req=4'b1000 -> gnt=4'b1000 and gnt_id=3 one cycle later.
- Rotation: req=4'b1111 with each owner dropping its req 1 cycle after grant -> grants in order 0,1,2,3,0 with no idle cycle between them.
- Hold expiry: req[0] held high from grant, req[2] rises -> req[0] keeps the grant for exactly 8 cycles, then gnt=4'b0100. ptr=3, so req[0] is served only after 2.
- Lone owner: only req[1] high for 50 cycles -> gnt=4'b0010 throughout with no expiry.
- Release to idle: single req[3] pulse of 3 cycles -> gnt high for cycles 2..4, then gnt=0 and IDLE. A new req[0] is granted 1 cycle later.
- ARB_RR_LOCK_EN: owner 0 with lock=1 and req[1] waiting for 20 cycles -> no handover. lock drops at cycle 20 -> gnt=4'b0010 after at most HOLD_MAX further cycles.

Source files
------------

// File: rtl/arbiter_rr_hold_pkg.sv
// arbiter_rr_pkg: shared defaults and types for the round-robin hold arbiter
package arbiter_rr_pkg;
  localparam int N_REQ = 4;
  localparam int HOLD_MAX_DEF = 8;
  typedef enum logic {IDLE, GRANT} arb_state_e;
  typedef logic [N_REQ-1:0] req_t;
  typedef logic [N_REQ-1:0] gnt_t;
  typedef logic [$clog2(N_REQ)-1:0] id_t;
endpackage

// File: rtl/arbiter_rr_hold_pick.sv
// rr_pick: lowest requester at or after ptr (wrapping), with an exclude mask
module rr_pick #(
  parameter int N = 4,
  parameter int IDW = $clog2(N)
) (
  input  logic [N-1:0]   req,
  input  logic [N-1:0]   excl_mask,
  input  logic [IDW-1:0] ptr,
  output logic           found,
  output logic [IDW-1:0] idx
);
  localparam logic [IDW:0] NL = (IDW+1)'(N);
  logic [N-1:0] m, rot;
  logic [IDW-1:0] pos;
  logic [IDW:0] sum;
  // rotate so ptr sits at bit 0, priority-encode, then rotate the index back
  always_comb begin
    m = req & ~excl_mask;
    rot = N'({m, m} >> ptr);
    found = |rot;
    pos = '0;
    for (int i = N - 1; i >= 0; i--) if (rot[i]) pos = IDW'(i);
    sum = {1'b0, pos} + {1'b0, ptr};
    idx = sum >= NL ? IDW'(sum - NL) : IDW'(sum);
  end
endmodule

// File: rtl/arbiter_rr_hold.sv
// arbiter_rr_hold: round-robin arbiter with bounded tenure; ARB_RR_LOCK_EN adds a lock input
module arbiter_rr_hold
  import arbiter_rr_pkg::*;
#(
  parameter int N = N_REQ,
  parameter int HOLD_MAX = HOLD_MAX_DEF,
  parameter int IDW = $clog2(N)
) (
  input  logic           clk,
  input  logic           rst,
`ifdef ARB_RR_LOCK_EN
  input  logic           lock,
`endif
  input  logic [N-1:0]   req,
  output logic [N-1:0]   gnt,
  output logic           gnt_vld,
  output logic [IDW-1:0] gnt_id
);
  localparam int HCW = $clog2(HOLD_MAX) + 1;
  arb_state_e state, state_nxt;
  logic [IDW-1:0] ptr, ptr_nxt, id_nxt, idx;
  logic [N-1:0] gnt_nxt;
  logic [HCW-1:0] hold_cnt, hold_nxt;
  logic found, others, rel, expire, take, lck;
`ifdef ARB_RR_LOCK_EN
  assign lck = lock;
`else
  assign lck = 1'b0;
`endif
  // gnt doubles as the owner mask: zero in IDLE, owner's bit in GRANT
  rr_pick #(.N(N), .IDW(IDW)) u_pick (
    .req(req),
    .excl_mask(gnt),
    .ptr(ptr),
    .found(found),
    .idx(idx)
  );
  // state, pointer, tenure counter and registered grant outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      ptr <= '0;
      hold_cnt <= '0;
      gnt <= '0;
      gnt_id <= '0;
    end else begin
      state <= state_nxt;
      ptr <= ptr_nxt;
      hold_cnt <= hold_nxt;
      gnt <= gnt_nxt;
      gnt_id <= id_nxt;
    end
  end
  // decide between new grant, continued tenure, or return to idle
  always_comb begin
    others = |(req & ~gnt);
    rel = (state == GRANT) && !(|(req & gnt));
    expire = (state == GRANT) && !rel && others && !lck && hold_cnt == HCW'(HOLD_MAX - 1);
    take = found && (state == IDLE || rel || expire);
    state_nxt = (take || (state == GRANT && !rel)) ? GRANT : IDLE;
    gnt_nxt = take ? {{(N-1){1'b0}}, 1'b1} << idx : (state_nxt == GRANT ? gnt : '0);
    id_nxt = take ? idx : gnt_id;
    ptr_nxt = take ? (idx == IDW'(N - 1) ? '0 : idx + 1'b1) : ptr;
    hold_nxt = (take || !others || state == IDLE) ? '0 : (lck ? hold_cnt : hold_cnt + 1'b1);
  end
  // grant-valid tracks the FSM state
  always_comb begin
    gnt_vld = (state == GRANT);
  end
endmodule
